// File: rtl/ahb_wait_sram_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ahb_wait_sram_slave                                          |
// | Description : AHB-Lite SRAM slave with a fixed number of wait states per   |
// |               OKAY data phase, byte/halfword/word writes on little-endian  |
// |               lanes and full-word reads. Defining AHB_SLV_ERR_EN compiles  |
// |               in the two-cycle ERROR response for illegal transfers.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ahb_wait_sram_slave #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t        state, next_state;
  logic [2:0]    wait_cnt, next_cnt;
  logic          dp_valid, next_valid;
  logic          dp_write, next_write;
  logic [AW-1:0] dp_idx, next_idx;
  logic [3:0]    dp_be, next_be;

  logic [31:0]   mem [0:DEPTH_WORDS-1];

  logic          ready;
  logic          accept;
  logic          illegal;
  logic          final_dp;
  logic [3:0]    lanes;
  logic [AW-1:0] addr_idx;
  logic          unused_ok;

  // Data phase completes in IDLE (no wait) or ERR2; only then can a new
  // address phase be taken, which also gives back-to-back pipelining.
  assign ready    = (state == ST_IDLE) || (state == ST_ERR2);
  assign accept   = HSEL & HREADY & HTRANS[1] & ready;
  assign final_dp = (state == ST_IDLE) & dp_valid;
  // Word index wraps naturally by keeping only the low AW bits.
  assign addr_idx = HADDR[AW+1:2];

  // Address bits above the index and HTRANS[0] carry no meaning for storage.
  assign unused_ok = ^{HTRANS[0], HADDR[31:AW+2], HSIZE[2]};

  // Byte lane enables; sizes above word fall into the word case.
  always_comb begin
    lanes = 4'b0000;
    case (HSIZE)
      3'b000:  lanes[HADDR[1:0]] = 1'b1;
      3'b001:  lanes = HADDR[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
  end

  // Legality check of the presented address phase.
  always_comb begin
`ifdef AHB_SLV_ERR_EN
    illegal = (HADDR[31:2] >= 30'(DEPTH_WORDS))
            | (HSIZE > 3'b010)
            | ((HSIZE == 3'b001) & HADDR[0])
            | ((HSIZE == 3'b010) & (HADDR[1:0] != 2'b00));
`else
    illegal = 1'b0;
`endif
  end

  // Next-state and data-phase capture logic.
  always_comb begin
    next_state = state;
    next_cnt   = wait_cnt;
    next_valid = dp_valid;
    next_write = dp_write;
    next_idx   = dp_idx;
    next_be    = dp_be;
    case (state)
      ST_WAIT: begin
        next_cnt = wait_cnt - 3'd1;
        if (wait_cnt <= 3'd1) begin
          next_state = ST_IDLE;
        end
      end
`ifdef AHB_SLV_ERR_EN
      ST_ERR1: next_state = ST_ERR2;
`endif
      default: begin
        next_state = ST_IDLE;
        next_valid = 1'b0;
        if (accept) begin
          if (illegal) begin
            next_state = ST_ERR1;
          end else begin
            next_valid = 1'b1;
            next_write = HWRITE;
            next_idx   = addr_idx;
            next_be    = lanes;
            if (WAIT_STATES > 0) begin
              next_state = ST_WAIT;
              next_cnt   = 3'(WAIT_STATES);
            end
          end
        end
      end
    endcase
  end

  // State and data-phase registers; reset discards any in-flight write.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      wait_cnt <= 3'd0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_be    <= 4'b0000;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
      dp_valid <= next_valid;
      dp_write <= next_write;
      dp_idx   <= next_idx;
      dp_be    <= next_be;
    end
  end

  // Write commit at the end of the final data-phase cycle; storage is not reset.
  always_ff @(posedge HCLK) begin
    if (final_dp && dp_write) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_be[i]) begin
          mem[dp_idx][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  // Bus responses derive only from registered state.
  always_comb begin
    HREADYOUT = ready;
    HRDATA    = (final_dp && !dp_write) ? mem[dp_idx] : 32'h0;
  end

`ifdef AHB_SLV_ERR_EN
  assign HRESP = (state == ST_ERR1) || (state == ST_ERR2);
`else
  assign HRESP = 1'b0;
`endif

endmodule
`default_nettype wire
